uart_tx_arbiter: RTL

- Shares one UART transmitter between NUM_REQ byte producers, using a round-robin policy.
- Accepts one byte per grant, drives the UART start/txin inputs, and waits for the UART txdone flag.
- After txdone, holds a guard interval so the stop bit completes and the UART returns to idle before the next start.
- Sits between client logic (status reporters, debug dumpers) and the UART block.

---
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between
// NUM_REQ byte producers. One byte per grant, then wait for txdone (or a
// timeout), then hold a guard interval so the stop bit drains before the
// next start strobe.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 20000,
    parameter int unsigned GUARD   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           done,
    output logic                         uart_start,
    output logic [DATA_W-1:0]            uart_txin,
    input  logic                         uart_txdone,
    output logic [$clog2(NUM_REQ)-1:0]   owner,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int unsigned OWN_W    = $clog2(NUM_REQ);
    localparam int unsigned CNT_MAXV = (TIMEOUT > GUARD) ? TIMEOUT : GUARD;
    localparam int unsigned CNT_W    = $clog2(CNT_MAXV + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GUARD = 2'd3
    } state_t;

    state_t             state;
    logic [OWN_W-1:0]   last;
    logic [CNT_W-1:0]   cnt;

    logic               req_any;
    logic [OWN_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [DATA_W-1:0]  win_data;
    logic [NUM_REQ-1:0] owner_oh;
    int                 pos;

    // Round-robin pick: first requester at last+1, last+2, ... (mod NUM_REQ).
    // Offsets are scanned from farthest to nearest so the nearest one wins.
    always_comb begin
        req_any  = |req;
        win_idx  = '0;
        win_oh   = '0;
        win_data = '0;
        pos      = 0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            pos = int'(last) + k;
            if (pos >= int'(NUM_REQ)) pos = pos - int'(NUM_REQ);
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (pos == i && req[i]) win_idx = OWN_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win_idx == OWN_W'(i)) begin
                win_oh[i] = 1'b1;
                win_data  = req_data[i*int'(DATA_W) +: DATA_W];
            end
        end
    end

    // One-hot decode of the current owner for the done pulse.
    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (owner == OWN_W'(i)) owner_oh[i] = 1'b1;
        end
    end

    // Arbiter FSM with registered outputs; reset lands in GUARD so a frame
    // that was on the wire when reset hit gets flushed before any new start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_GUARD;
            cnt         <= '0;
            last        <= OWN_W'(NUM_REQ - 1);
            owner       <= '0;
            grant       <= '0;
            done        <= '0;
            uart_start  <= 1'b0;
            uart_txin   <= '0;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            grant       <= '0;
            done        <= '0;
            uart_start  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        uart_txin <= win_data;
                        owner     <= win_idx;
                        last      <= win_idx;
                        grant     <= win_oh;
                        state     <= S_START;
                        busy      <= 1'b1;
                    end
                end
                S_START: begin
                    uart_start <= 1'b1;
                    cnt        <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (uart_txdone) begin
                        done  <= owner_oh;
                        cnt   <= '0;
                        state <= S_GUARD;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        cnt         <= '0;
                        state       <= S_GUARD;
                    end else if (cnt != CNT_W'(CNT_MAXV)) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_GUARD: begin
                    if (cnt >= CNT_W'(GUARD - 1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt != CNT_W'(CNT_MAXV)) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_GUARD;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule
